seq_div: RTL

//   Multi-cycle signed 32-bit integer divider for the ALU datapath. It performs the inverse of
//   the multiply path using iterative subtraction in the same add/sub style as the ALU.

---
 rtl/seq_div.sv | 122 ++++++++++++
 1 files changed

// File: rtl/seq_div.sv
// Multi-cycle signed integer divider: restoring algorithm, one quotient bit per clock.
// Operands are reduced to magnitudes on acceptance; signs are reapplied in a single fix-up cycle.
module seq_div #(
    parameter int WIDTH = 32
) (
    input  logic             clock_seqdiv,
    input  logic             reset_n_seqdiv,
    input  logic             start_seqdiv,
    input  logic [WIDTH-1:0] in1_seqdiv,
    input  logic [WIDTH-1:0] in2_seqdiv,
    output logic             busy_seqdiv,
    output logic             ready_seqdiv,
    output logic [WIDTH-1:0] quot_seqdiv,
    output logic [WIDTH-1:0] rem_seqdiv,
    output logic             dbz_seqdiv,
    output logic             ovf_seqdiv
);

    localparam int CNT_W = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(WIDTH - 1);
    localparam logic [WIDTH-1:0] MOST_NEG  = {1'b1, {(WIDTH-1){1'b0}}};

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        FIX
    } state_t;

    state_t            state;
    logic [CNT_W-1:0]  iter_cnt;

    logic [WIDTH:0]    rem_acc;
    logic [WIDTH-1:0]  dvd_sh;
    logic [WIDTH-1:0]  dvs_mag;
    logic              sign_dvd;
    logic              sign_dvs;
    logic              dbz_pend;
    logic              ovf_pend;

    logic [WIDTH:0]    shifted;
    logic [WIDTH:0]    trial;
    logic              q_bit;
    logic              accept;

    // Unsigned magnitude; the most-negative value maps to 2^(WIDTH-1) exactly.
    function automatic logic [WIDTH-1:0] magnitude(input logic signed [WIDTH-1:0] v);
        logic signed [WIDTH-1:0] neg_v;
        neg_v = -v;
        return v[WIDTH-1] ? neg_v : v;
    endfunction

    function automatic logic [WIDTH-1:0] apply_sign(input logic [WIDTH-1:0] mag, input logic neg);
        return neg ? (~mag + WIDTH'(1)) : mag;
    endfunction

    assign accept  = start_seqdiv && !busy_seqdiv;
    assign shifted = {rem_acc[WIDTH-1:0], dvd_sh[WIDTH-1]};
    assign trial   = shifted - {1'b0, dvs_mag};
    // A set top bit means the shifted remainder certainly exceeds the divisor.
    assign q_bit   = rem_acc[WIDTH] | ~trial[WIDTH];

    // Operand capture and iteration datapath
    always_ff @(posedge clock_seqdiv) begin
        if (accept) begin
            dvd_sh   <= magnitude(in1_seqdiv);
            dvs_mag  <= magnitude(in2_seqdiv);
            sign_dvd <= in1_seqdiv[WIDTH-1];
            sign_dvs <= in2_seqdiv[WIDTH-1];
            rem_acc  <= '0;
            dbz_pend <= (in2_seqdiv == '0);
            ovf_pend <= (in1_seqdiv == MOST_NEG) && (&in2_seqdiv);
        end else if (state == RUN) begin
            rem_acc  <= q_bit ? trial : shifted;
            dvd_sh   <= {dvd_sh[WIDTH-2:0], q_bit};
        end
    end

    // Sequencing, sign fix-up and result registers
    always_ff @(posedge clock_seqdiv or negedge reset_n_seqdiv) begin
        if (!reset_n_seqdiv) begin
            state        <= IDLE;
            iter_cnt     <= '0;
            busy_seqdiv  <= 1'b0;
            ready_seqdiv <= 1'b0;
            quot_seqdiv  <= '0;
            rem_seqdiv   <= '0;
            dbz_seqdiv   <= 1'b0;
            ovf_seqdiv   <= 1'b0;
        end else begin
            ready_seqdiv <= 1'b0;
            case (state)
                IDLE: begin
                    if (accept) begin
                        busy_seqdiv <= 1'b1;
                        dbz_seqdiv  <= 1'b0;
                        ovf_seqdiv  <= 1'b0;
                        iter_cnt    <= '0;
                        state       <= (in2_seqdiv == '0) ? FIX : RUN;
                    end else if (ready_seqdiv) begin
                        busy_seqdiv <= 1'b0;
                    end
                end
                RUN: begin
                    iter_cnt <= iter_cnt + CNT_W'(1);
                    if (iter_cnt == LAST_ITER) begin
                        state <= FIX;
                    end
                end
                FIX: begin
                    quot_seqdiv  <= dbz_pend ? '0 : apply_sign(dvd_sh, sign_dvd ^ sign_dvs);
                    rem_seqdiv   <= apply_sign(dbz_pend ? dvd_sh : rem_acc[WIDTH-1:0], sign_dvd);
                    dbz_seqdiv   <= dbz_pend;
                    ovf_seqdiv   <= ovf_pend;
                    ready_seqdiv <= 1'b1;
                    state        <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
